// File: rtl/fuzzy_sweep_sequencer.sv
// Sweeps the fuzzy controller's two inputs over a clamped grid, captures the
// defuzzified output per point, then streams the captured table over valid/ready.
module fuzzy_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STEP          = 16,
  parameter int N_STEPS       = 17,
  parameter int IN_MIN        = 1,
  parameter int IN_MAX        = 254
) (
  input  logic       clk_0,
  input  logic       Srst,
  input  logic       start,
  input  logic [7:0] saida_defuzzy,
  output logic [7:0] Entrada_01,
  output logic [7:0] Entrada_02,
  output logic       EN_REGRAS,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int N_PTS = N_STEPS * N_STEPS;
  localparam int AW    = $clog2(N_PTS);
  localparam int IW    = $clog2(N_STEPS);
  localparam int CW    = $clog2(SETTLE_CYCLES);

  localparam logic [AW-1:0] LAST_K   = AW'(N_PTS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STEPS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  logic [IW-1:0]   a_q, a_d;
  logic [IW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            wr_en, rd_en;
  logic [7:0]      rd_data_q;
  logic [7:0]      buf_mem [N_PTS];

  // Index 0 maps below IN_MIN and the top index above IN_MAX, so both ends clamp.
  function automatic logic [7:0] axis_value(input logic [IW-1:0] idx);
    int raw;
    raw = int'(idx) * STEP;
    if (raw < IN_MIN)      raw = IN_MIN;
    else if (raw > IN_MAX) raw = IN_MAX;
    return 8'(raw);
  endfunction

  assign Entrada_01 = axis_value(a_q);
  assign Entrada_02 = axis_value(b_q);
  assign EN_REGRAS  = (state_q == S_SWEEP);
  assign busy       = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_valid_q ? rd_data_q : 8'd0;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          k_d     = '0;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
        end
      end

      S_SWEEP: begin
        if (cnt_q == LAST_CNT) begin
          wr_en = 1'b1;
          cnt_d = '0;
          if (k_q == LAST_K) begin
            state_d  = S_DRAIN;
            rd_ptr_d = '0;
          end else begin
            k_d = k_q + 1'b1;
            if (b_q == LAST_IDX) begin
              b_d = '0;
              a_d = a_q + 1'b1;
            end else begin
              b_d = b_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // Fetch the next entry whenever the output slot is empty or being emptied,
        // which keeps the stream bubble-free under continuous ready.
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
          k_d         = '0;
          a_d         = '0;
          b_d         = '0;
        end else if (!out_valid_q || out_ready) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == LAST_K);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the buffer and its read register carry no reset so they map onto block RAM;
  // out_data is gated by out_valid to still read zero after reset.
  always_ff @(posedge clk_0) begin
    if (wr_en) buf_mem[k_q] <= saida_defuzzy;
    if (rd_en) rd_data_q <= buf_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_fuzzy_sweep_sequencer.sv
// Self-checking bench for fuzzy_sweep_sequencer: randomized masks and ready patterns
// checked against a grid/table model derived directly from the sweep rules.
module tb_fuzzy_sweep_sequencer;

  localparam int SETTLE = 4;
  localparam int NPTS   = 289;

  logic       clk_0 = 1'b0;
  logic       Srst  = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] saida_defuzzy;
  logic [7:0] Entrada_01, Entrada_02, out_data;
  logic       EN_REGRAS, busy, done, out_valid, out_last;

  logic       ovr_en  = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  logic [7:0] mask    = 8'h00;

  int checks   = 0;
  int failures = 0;

  logic [7:0] axis_tbl [17];
  logic [7:0] exp_q    [NPTS];
  logic [7:0] got      [NPTS];

  assign saida_defuzzy = ovr_en ? ovr_val : (Entrada_01 ^ Entrada_02 ^ mask);

  fuzzy_sweep_sequencer #(
    .SETTLE_CYCLES(SETTLE), .STEP(16), .N_STEPS(17), .IN_MIN(1), .IN_MAX(254)
  ) dut (
    .clk_0(clk_0), .Srst(Srst), .start(start), .saida_defuzzy(saida_defuzzy),
    .Entrada_01(Entrada_01), .Entrada_02(Entrada_02), .EN_REGRAS(EN_REGRAS),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk_0 = ~clk_0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_e1"},    Entrada_01, 8'd1);
    check({tag, "_e2"},    Entrada_02, 8'd1);
    check({tag, "_en"},    EN_REGRAS,  1'b0);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_done"},  done,       1'b0);
    check({tag, "_valid"}, out_valid,  1'b0);
    check({tag, "_data"},  out_data,   8'd0);
    check({tag, "_last"},  out_last,   1'b0);
  endtask

  // cap_mode: 0 none, 1 = input changes after point 5's capture, 2 = before it.
  // ready_mode: 0 always ready, 1 = 1,0,0,1,0,1 pattern, 2 = random.
  task automatic run_sweep(input logic [7:0] m, input int cap_mode, input int ready_mode,
                           input bit hold_end, input bit pre_started, input int abort_at);
    int cyc, p, seq_err, stat_err;
    int dcyc, first_valid, n_xfer, data_err, last_err, stab_err, dstat_err;
    bit prev_hold, done_seen;
    logic [7:0] prev_data;
    logic prev_last;

    mask = m;
    for (int k = 0; k < NPTS; k++) begin
      exp_q[k] = axis_tbl[k / 17] ^ axis_tbl[k % 17] ^ m;
      got[k]   = 'x;
    end
    if (cap_mode == 1) exp_q[5] = 8'hAA;
    else if (cap_mode == 2) exp_q[5] = 8'h55;

    if (!pre_started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("sweep_entered", EN_REGRAS, 1'b1);
    check("sweep_first_pair", {Entrada_01, Entrada_02}, 16'h0101);

    cyc = 0; seq_err = 0; stat_err = 0;
    while (EN_REGRAS === 1'b1 && cyc < 2000) begin
      p = cyc / SETTLE;
      if (p >= NPTS || Entrada_01 !== axis_tbl[p / 17] || Entrada_02 !== axis_tbl[p % 17])
        seq_err++;
      if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) stat_err++;
      if (cap_mode != 0 && cyc >= 20 && cyc <= 24) begin
        ovr_en  = 1'b1;
        ovr_val = (cyc >= ((cap_mode == 1) ? 24 : 23)) ? 8'h55 : 8'hAA;
      end else begin
        ovr_en = 1'b0;
      end
      start = ($urandom_range(0, 39) == 0);
      if (cyc == abort_at) begin
        #3 Srst = 1'b0;
        #1 check_reset_outputs("abort_reset");
        start  = 1'b0;
        ovr_en = 1'b0;
        tick();
        tick();
        check_reset_outputs("abort_held");
        #2 Srst = 1'b1;
        tick();
        tick();
        check("abort_stays_idle", EN_REGRAS, 1'b0);
        return;
      end
      tick();
      cyc++;
    end
    ovr_en = 1'b0;
    check("sweep_cycles", cyc, NPTS * SETTLE);
    check("sweep_seq_errs", seq_err, 0);
    check("sweep_status_errs", stat_err, 0);
    check("drain_inputs_held", {Entrada_01, Entrada_02}, 16'hFEFE);

    dcyc = 0; first_valid = -1; n_xfer = 0; data_err = 0; last_err = 0;
    stab_err = 0; dstat_err = 0; prev_hold = 0; done_seen = 0;
    prev_data = '0; prev_last = 1'b0;
    while (!done_seen && dcyc < 3000) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (dcyc % 6 == 0) || (dcyc % 6 == 3) || (dcyc % 6 == 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done === 1'b1) begin
        done_seen = 1;
        if (busy !== 1'b0) dstat_err++;
        start = 1'b1;
      end else begin
        if (busy !== 1'b1) dstat_err++;
        start = hold_end ? (dcyc > 20) : ($urandom_range(0, 19) == 0);
      end
      if (EN_REGRAS !== 1'b0) dstat_err++;
      if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stab_err++;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = dcyc;
      if (out_valid === 1'b1 && out_ready) begin
        if (n_xfer < NPTS) begin
          got[n_xfer] = out_data;
          if (out_data !== exp_q[n_xfer]) data_err++;
        end
        if (out_last !== (n_xfer == NPTS - 1)) last_err++;
        n_xfer++;
      end
      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      tick();
      dcyc++;
    end

    check("done_seen", done_seen, 1);
    check("first_valid_cycle", first_valid, 1);
    check("xfer_count", n_xfer, NPTS);
    check("data_errs", data_err, 0);
    check("last_errs", last_err, 0);
    check("stability_errs", stab_err, 0);
    check("drain_status_errs", dstat_err, 0);
    check("done_one_cycle", done, 1'b0);
    if (hold_end) begin
      check("idle_after_done", EN_REGRAS, 1'b0);
      tick();
      check("restart_2_cycles", EN_REGRAS, 1'b1);
      start = 1'b0;
    end else begin
      start = 1'b0;
      check("idle_busy", busy, 1'b0);
      tick();
      check("done_start_ignored", EN_REGRAS, 1'b0);
    end
  endtask

  initial begin
    axis_tbl[0]  = 8'd1;
    for (int i = 1; i < 16; i++) axis_tbl[i] = 8'(i * 16);
    axis_tbl[16] = 8'd254;

    #2 Srst = 1'b0;
    #1 check_reset_outputs("por_async");
    tick();
    tick();
    #2 Srst = 1'b1;
    tick();
    tick();
    check_reset_outputs("idle");

    run_sweep(8'h00, 0, 0, 1'b0, 1'b0, -1);
    check("entry0", got[0], 8'h00);
    check("entry16", got[16], 8'hFF);
    check("entry17", got[17], 8'h11);
    check("entry288", got[288], 8'h00);

    run_sweep(8'($urandom), 0, 1, 1'b1, 1'b0, -1);
    run_sweep(8'($urandom), 1, 2, 1'b0, 1'b1, -1);
    check("capture_after_edge", got[5], 8'hAA);
    run_sweep(8'($urandom), 2, 2, 1'b0, 1'b0, -1);
    check("capture_before_edge", got[5], 8'h55);

    run_sweep(8'($urandom), 0, 0, 1'b0, 1'b0, 400);
    run_sweep(8'($urandom), 0, 2, 1'b0, 1'b0, -1);
    check("post_abort_entry100", got[100], exp_q[100]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
